mc_control_fsm: RTL



---
 rtl/ctrl_pkg.sv | 63 ++++++
 rtl/main_decoder.sv | 35 +++
 rtl/mc_control_fsm.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ctrl_pkg                                                         |
// | Shared types and opcode constants for the multi-cycle sequencer. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JALR   = 2'd2
    } pc_src_t;

    typedef enum logic [1:0] {
        ALU_A_RS1  = 2'd0,
        ALU_A_PC   = 2'd1,
        ALU_A_ZERO = 2'd2
    } alu_src_a_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_t;

    typedef enum logic [3:0] {
        CLS_LUI    = 4'd0,
        CLS_AUIPC  = 4'd1,
        CLS_JAL    = 4'd2,
        CLS_JALR   = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_LOAD   = 4'd5,
        CLS_STORE  = 4'd6,
        CLS_IMM    = 4'd7,
        CLS_OP     = 4'd8,
        CLS_FENCE  = 4'd9,
        CLS_NONE   = 4'd10
    } instr_class_t;

endpackage
`default_nettype wire

// File: rtl/main_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | main_decoder                                                     |
// | Combinational opcode to instruction-class decode with legal flag.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module main_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_t instr_class,
    output logic         legal
);

    // SYSTEM has no entry here, so it lands in the illegal default
    always_comb begin
        instr_class = CLS_NONE;
        legal       = 1'b1;
        case (opcode)
            OP_LUI:    instr_class = CLS_LUI;
            OP_AUIPC:  instr_class = CLS_AUIPC;
            OP_JAL:    instr_class = CLS_JAL;
            OP_JALR:   instr_class = CLS_JALR;
            OP_BRANCH: instr_class = CLS_BRANCH;
            OP_LOAD:   instr_class = CLS_LOAD;
            OP_STORE:  instr_class = CLS_STORE;
            OP_IMM:    instr_class = CLS_IMM;
            OP_OP:     instr_class = CLS_OP;
            OP_FENCE:  instr_class = CLS_FENCE;
            default:   legal       = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc_control_fsm                                                   |
// | Multi-cycle RV32I sequencer: fetch/decode/exec/mem/wb with traps.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mc_control_fsm
    import ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       br_taken,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_a,
    output logic       alu_src_b,
    output logic [1:0] wb_sel,
    output logic       rf_we,
    output logic       instret,
    output logic       illegal
);

    state_t       r_state;
    state_t       w_state_next;
    instr_class_t w_class;
    logic         w_legal;

    // RESET_PC and funct3 belong to the datapath; they pass by this block
    logic w_unused_ok;
    assign w_unused_ok = ^{funct3, RESET_PC};

    main_decoder u_main_decoder (
        .opcode      (opcode),
        .instr_class (w_class),
        .legal       (w_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Outputs are forced low during the reset cycle regardless of state
    always_comb begin
        w_state_next = r_state;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_PLUS4;
        alu_src_a    = ALU_A_RS1;
        alu_src_b    = 1'b0;
        wb_sel       = WB_ALU;
        rf_we        = 1'b0;
        instret      = 1'b0;
        illegal      = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_we        = 1'b1;
                        w_state_next = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    w_state_next = w_legal ? ST_EXEC : ST_TRAP;
                end
                ST_EXEC: begin
                    case (w_class)
                        CLS_IMM, CLS_LOAD, CLS_STORE, CLS_JALR: alu_src_b = 1'b1;
                        CLS_LUI: begin
                            alu_src_a = ALU_A_ZERO;
                            alu_src_b = 1'b1;
                        end
                        CLS_AUIPC: begin
                            alu_src_a = ALU_A_PC;
                            alu_src_b = 1'b1;
                        end
                        default: ;
                    endcase
                    case (w_class)
                        CLS_BRANCH: begin
                            pc_we        = 1'b1;
                            instret      = 1'b1;
                            pc_src       = br_taken ? PC_BRANCH : PC_PLUS4;
                            w_state_next = ST_FETCH;
                        end
                        CLS_FENCE: begin
                            pc_we        = 1'b1;
                            instret      = 1'b1;
                            w_state_next = ST_FETCH;
                        end
                        CLS_LOAD, CLS_STORE: w_state_next = ST_MEM;
                        default:             w_state_next = ST_WB;
                    endcase
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (w_class == CLS_STORE);
                    if (dmem_ack) begin
                        if (w_class == CLS_STORE) begin
                            pc_we        = 1'b1;
                            instret      = 1'b1;
                            w_state_next = ST_FETCH;
                        end else begin
                            w_state_next = ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    rf_we   = 1'b1;
                    pc_we   = 1'b1;
                    instret = 1'b1;
                    case (w_class)
                        CLS_LOAD: wb_sel = WB_LOAD;
                        CLS_JAL: begin
                            wb_sel = WB_PC4;
                            pc_src = PC_BRANCH;
                        end
                        CLS_JALR: begin
                            wb_sel = WB_PC4;
                            pc_src = PC_JALR;
                        end
                        default: ;
                    endcase
                    w_state_next = ST_FETCH;
                end
                ST_TRAP: begin
                    illegal = 1'b1;
                end
                default: w_state_next = ST_FETCH;
            endcase
        end
    end

endmodule
`default_nettype wire
